// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding RV32I load/store at a time, with a
// fixed response latency and valid/ready handshakes on request and response.
module dmem_responder #(
  parameter int CPU_WIDTH = 32,
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [2:0]           req_func3_i,
  input  logic [ADDR_W-1:0]    req_addr_i,
  input  logic [CPU_WIDTH-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [CPU_WIDTH-1:0] rsp_rdata_o,
  output logic                 rsp_err_o
);

  localparam int NB     = CPU_WIDTH / 8;
  localparam int WORD_W = $clog2(DEPTH);
  localparam int CNT_W  = 4;
  localparam logic [ADDR_W:0]    ADDR_LIMIT = (ADDR_W + 1)'(DEPTH * 4);
  localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;

  logic                 we_q;
  logic [2:0]           func3_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [CPU_WIDTH-1:0] wdata_q;

  logic [CPU_WIDTH-1:0] rdata_q;
  logic                 err_q;

  logic                 accept;
  logic                 access;
  logic                 err;
  logic                 bad_func3;
  logic                 misaligned;
  logic                 out_of_range;
  logic [WORD_W-1:0]    word_idx;
  logic [CPU_WIDTH-1:0] rd_word;
  logic [7:0]           rd_byte;
  logic [15:0]          rd_half;
  logic [CPU_WIDTH-1:0] load_data;
  logic [NB-1:0]        byte_en;
  logic [CPU_WIDTH-1:0] store_data;

  logic [CPU_WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    accept      = 1'b0;
    access      = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready_o = !rst_i;
        if (req_valid_i && !rst_i) begin
          accept     = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // The counter counts down to zero; the edge leaving zero enters RESP,
        // which lands exactly LATENCY edges after the accept edge.
        if (cnt == '0) begin
          access     = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (access) begin
        rdata_q <= (err || we_q) ? '0 : load_data;
        err_q   <= err;
      end else if (rsp_valid_o && rsp_ready_i) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  // Request fields are pure datapath: only meaningful after an accept.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= req_we_i;
      func3_q <= req_func3_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Request decode: legality, lane selection, load extension
  // ---------------------------------------------------------------------------
  always_comb begin
    bad_func3  = 1'b0;
    misaligned = 1'b0;
    if (we_q) bad_func3 = (func3_q > 3'd2);
    else      bad_func3 = (func3_q == 3'd3) || (func3_q == 3'd6) || (func3_q == 3'd7);
    // func3[1:0] encodes the access size for both loads and stores.
    case (func3_q[1:0])
      2'd1:    misaligned = addr_q[0];
      2'd2:    misaligned = |addr_q[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign out_of_range = ({1'b0, addr_q} >= ADDR_LIMIT);
  assign err          = bad_func3 || misaligned || out_of_range;
  assign word_idx     = addr_q[WORD_W+1:2];

  always_comb begin
    rd_word   = mem[word_idx];
    rd_byte   = rd_word[{addr_q[1:0], 3'b000} +: 8];
    rd_half   = rd_word[{addr_q[1], 4'b0000} +: 16];
    load_data = '0;
    case (func3_q)
      3'd0:    load_data = {{(CPU_WIDTH-8){rd_byte[7]}}, rd_byte};
      3'd1:    load_data = {{(CPU_WIDTH-16){rd_half[15]}}, rd_half};
      3'd2:    load_data = rd_word;
      3'd4:    load_data = {{(CPU_WIDTH-8){1'b0}}, rd_byte};
      3'd5:    load_data = {{(CPU_WIDTH-16){1'b0}}, rd_half};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    byte_en    = '0;
    store_data = wdata_q;
    case (func3_q[1:0])
      2'd0: begin
        byte_en    = NB'(1) << addr_q[1:0];
        store_data = {NB{wdata_q[7:0]}};
      end
      2'd1: begin
        byte_en    = NB'(3) << {addr_q[1], 1'b0};
        store_data = {(NB/2){wdata_q[15:0]}};
      end
      2'd2:    byte_en = '1;
      default: byte_en = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the memory array has no reset; contents survive rst_i by design.
  always_ff @(posedge clk_i) begin
    if (access && we_q && !err && !rst_i) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a reference memory model predicts each
// response at accept time; responses are compared when handshaken.
module tb_dmem_responder;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_we;
  logic [2:0]    req_func3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;

  logic          req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          v1, rdy1, rv1, rr1, re1;
  logic [31:0]   rd1;
  logic          v15, rdy15, rv15, rr15, re15;
  logic [31:0]   rd15;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        sb_q[$];
  logic [31:0] mdl [256];
  int          acc_edge = 0;
  bit          rv_prev  = 1'b0;

  dmem_responder #(.CPU_WIDTH(32), .ADDR_W(AW), .DEPTH(256), .LATENCY(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_func3_i(req_func3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  dmem_responder #(.CPU_WIDTH(32), .ADDR_W(AW), .DEPTH(256), .LATENCY(1)) dut_l1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(v1), .req_ready_o(rdy1), .req_we_i(req_we),
    .req_func3_i(req_func3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rv1), .rsp_ready_i(rr1),
    .rsp_rdata_o(rd1), .rsp_err_o(re1)
  );

  dmem_responder #(.CPU_WIDTH(32), .ADDR_W(AW), .DEPTH(256), .LATENCY(15)) dut_l15 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(v15), .req_ready_o(rdy15), .req_we_i(req_we),
    .req_func3_i(req_func3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rv15), .rsp_ready_i(rr15),
    .rsp_rdata_o(rd15), .rsp_err_o(re15)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at time %0t", $time);
    $fatal(1);
  end

  // Reference model: legality check, then load extraction or store merge.
  function automatic rsp_t model(input logic we, input logic [2:0] f3,
                                 input logic [AW-1:0] a, input logic [31:0] wd);
    rsp_t        r;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    bit          bad;
    int          bsh;
    int          hsh;
    r.rdata = '0;
    r.err   = 1'b0;
    bad = (a >= AW'(1024));
    if (we) bad = bad || (f3 > 3'd2);
    else    bad = bad || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    if (f3 == 3'd1 || f3 == 3'd5) bad = bad || a[0];
    if (f3 == 3'd2) bad = bad || (a[1:0] != 2'b00);
    if (bad) begin
      r.err = 1'b1;
      return r;
    end
    bsh = 8 * int'(a[1:0]);
    hsh = 16 * int'(a[1]);
    w = mdl[a[9:2]];
    b = w[bsh +: 8];
    h = w[hsh +: 16];
    if (we) begin
      case (f3)
        3'd0:    w[bsh +: 8]  = wd[7:0];
        3'd1:    w[hsh +: 16] = wd[15:0];
        default: w = wd;
      endcase
      mdl[a[9:2]] = w;
    end else begin
      case (f3)
        3'd0:    r.rdata = {{24{b[7]}}, b};
        3'd1:    r.rdata = {{16{h[15]}}, h};
        3'd2:    r.rdata = w;
        3'd4:    r.rdata = {24'h0, b};
        default: r.rdata = {16'h0, h};
      endcase
    end
    return r;
  endfunction

  // Scoreboard monitor on the LATENCY=2 instance, sampled on the falling edge.
  always @(negedge clk) begin
    rsp_t exp;
    if (rst) begin
      rv_prev = 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        sb_q.push_back(model(req_we, req_func3, req_addr, req_wdata));
        acc_edge = cyc + 1;
      end
      if (rsp_valid && !rv_prev) begin
        checks++;
        if (cyc - acc_edge != 2) begin
          errors++;
          $display("FAIL latency: got %0d edges after accept, expected 2", cyc - acc_edge);
        end
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got rdata %h err %b with no request pending",
                   rsp_rdata, rsp_err);
        end else begin
          exp = sb_q.pop_front();
          if (rsp_rdata !== exp.rdata || rsp_err !== exp.err) begin
            errors++;
            $display("FAIL response: got rdata %h err %b, expected rdata %h err %b",
                     rsp_rdata, rsp_err, exp.rdata, exp.err);
          end
        end
      end
      rv_prev = rsp_valid;
    end
  end

  // One full transaction on the main instance; the monitor does the checking.
  task automatic send(input logic we, input logic [2:0] f3,
                      input logic [AW-1:0] a, input logic [31:0] wd);
    int n;
    @(posedge clk); #1;
    req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 20);
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready got %b, expected 1", req_ready);
    end
    @(posedge clk); #1;
    // Scramble the unused request fields; they must be ignored without a handshake.
    req_valid = 1'b0;
    req_addr  = AW'($urandom);
    req_wdata = $urandom;
    req_func3 = 3'($urandom);
    n = 0;
    do begin @(negedge clk); n++; end while (!(rsp_valid && rsp_ready) && n < 40);
    if (!(rsp_valid && rsp_ready)) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: rsp_valid got %b, expected 1", rsp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rdy1 !== 1'b0 || rdy15 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: got %b%b%b, expected 000", req_ready, rdy1, rdy15);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp_valid: got %b, expected 0", rsp_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rdy1 !== 1'b1 || rdy15 !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready: got %b%b%b, expected 111", req_ready, rdy1, rdy15);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_rsp: got valid %b rdata %h err %b, expected 0 0 0",
               rsp_valid, rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_word();
    send(1'b1, 3'd2, 12'h010, 32'hDEADBEEF);
    send(1'b0, 3'd2, 12'h010, 32'h0);
  endtask

  task automatic test_extension();
    send(1'b0, 3'd0, 12'h013, 32'h0);          // LB
    send(1'b0, 3'd4, 12'h013, 32'h0);          // LBU
    send(1'b0, 3'd1, 12'h010, 32'h0);          // LH
    send(1'b0, 3'd5, 12'h012, 32'h0);          // LHU
    send(1'b1, 3'd0, 12'h011, 32'hAAAAAA12);   // SB lane 1
    send(1'b0, 3'd2, 12'h010, 32'h0);
    send(1'b1, 3'd1, 12'h016, 32'h5555C0DE);   // SH upper half of word 0x014
    send(1'b0, 3'd5, 12'h016, 32'h0);
    send(1'b0, 3'd1, 12'h016, 32'h0);
  endtask

  task automatic test_errors();
    send(1'b1, 3'd1, 12'h011, 32'hFFFFFFFF);   // misaligned SH
    send(1'b0, 3'd2, 12'h010, 32'h0);
    send(1'b0, 3'd2, 12'h012, 32'h0);          // misaligned LW
    send(1'b0, 3'd1, 12'h011, 32'h0);          // misaligned LH
    send(1'b0, 3'd2, 12'h400, 32'h0);          // out of range
    send(1'b1, 3'd2, 12'h400, 32'h12345678);   // out-of-range store
    send(1'b0, 3'd3, 12'h010, 32'h0);          // illegal load funct3
    send(1'b1, 3'd3, 12'h010, 32'h0BADF00D);   // illegal store funct3
    send(1'b0, 3'd2, 12'h010, 32'h0);
  endtask

  task automatic test_backpressure();
    logic [31:0] snap;
    int          n;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_we = 1'b0; req_func3 = 3'd2; req_addr = 12'h010; req_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 20);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_rsp_valid: got %b, expected 1", rsp_valid);
    end
    snap = rsp_rdata;
    checks++;
    if (snap !== 32'hDEAD12EF) begin
      errors++;
      $display("FAIL bp_rdata: got %h, expected deadbeef with byte1=12 (dead12ef)", snap);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== snap || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: got valid %b rdata %h err %b ready %b, expected 1 %h 0 0",
                 rsp_valid, rsp_rdata, rsp_err, req_ready, snap);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got ready %b valid %b, expected 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] saved;
    int          n;
    send(1'b1, 3'd2, 12'h020, 32'h11223344);
    saved = mdl[8];
    @(posedge clk); #1;
    req_we = 1'b1; req_func3 = 3'd2; req_addr = 12'h020; req_wdata = 32'h55AA55AA;
    req_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 20);
    @(posedge clk); #1;          // accept edge; the responder is now in WAIT
    req_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL midop_abort: got valid %b ready %b, expected 0 1", rsp_valid, req_ready);
      end
    end
    // The aborted store was never performed: drop its prediction and undo its model write.
    sb_q.delete();
    mdl[8] = saved;
    send(1'b0, 3'd2, 12'h020, 32'h0);
  endtask

  // Requests held continuously: each response arrives LATENCY edges after its
  // accept, and the next accept follows one handshake edge plus one IDLE edge.
  task automatic test_back_to_back(input int lat);
    int          acc[$];
    int          rise[$];
    bit          prev;
    bit          rdy, rv, vv;
    logic [31:0] rd;
    logic        er;
    int          bad_payload;
    prev        = 1'b0;
    bad_payload = 0;
    @(posedge clk); #1;
    req_we = 1'b1; req_func3 = 3'd2; req_addr = 12'h004; req_wdata = 32'hA5A50000 + lat;
    if (lat == 1) v1 = 1'b1; else v15 = 1'b1;
    for (int c = 0; c < 200 && rise.size() < 3; c++) begin
      @(negedge clk);
      rdy = (lat == 1) ? rdy1 : rdy15;
      rv  = (lat == 1) ? rv1  : rv15;
      vv  = (lat == 1) ? v1   : v15;
      rd  = (lat == 1) ? rd1  : rd15;
      er  = (lat == 1) ? re1  : re15;
      if (rv && !prev) begin
        rise.push_back(cyc);
        if (rd !== 32'h0 || er !== 1'b0) bad_payload++;
      end
      prev = rv;
      if (vv && rdy) begin
        acc.push_back(cyc + 1);
        if (acc.size() == 3) begin
          @(posedge clk); #1;
          v1  = 1'b0;
          v15 = 1'b0;
        end
      end
    end
    checks++;
    if (acc.size() != 3 || rise.size() != 3) begin
      errors++;
      $display("FAIL b2b_count_L%0d: got %0d accepts %0d responses, expected 3 3",
               lat, acc.size(), rise.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rise[i] - acc[i] != lat) begin
          errors++;
          $display("FAIL b2b_latency_L%0d: got %0d edges, expected %0d", lat, rise[i] - acc[i], lat);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc[i] - acc[i-1] != lat + 2) begin
          errors++;
          $display("FAIL b2b_spacing_L%0d: got %0d edges, expected %0d",
                   lat, acc[i] - acc[i-1], lat + 2);
        end
      end
    end
    checks++;
    if (bad_payload != 0) begin
      errors++;
      $display("FAIL b2b_payload_L%0d: got %0d nonzero store responses, expected 0", lat, bad_payload);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; rsp_ready = 1'b1;
    v1 = 1'b0; v15 = 1'b0; rr1 = 1'b1; rr15 = 1'b1;
    req_we = 1'b0; req_func3 = 3'd0; req_addr = '0; req_wdata = '0;

    test_reset();
    test_word();
    test_extension();
    test_errors();
    test_backpressure();
    test_reset_midop();
    test_back_to_back(1);
    test_back_to_back(15);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d responses outstanding, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
